// File: rtl/systolic_ctrl_pkg.sv
// Shared definitions for the systolic array tile controller: array geometry,
// datapath widths, drain latency, counter widths and FSM state encodings.
package systolic_ctrl_pkg;

  localparam int unsigned ARRAY_DIM  = 8;
  localparam int unsigned WORD_WIDTH = 16;
  // Accumulator width: full product plus headroom for up to 255 terms.
  localparam int unsigned DATA_WIDTH = 2 * WORD_WIDTH + 8;
  // Register stage between the last array row and the output mux.
  localparam int unsigned OUTPUT_LAT = 1;
  // Cycles from we_o to column-0 result valid at the array output.
  localparam int unsigned DRAIN_LAT  = ARRAY_DIM + OUTPUT_LAT;

  localparam int unsigned K_W   = 8;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned COL_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FEED  = 3'd1,
    ST_FLUSH = 3'd2,
    ST_DRAIN = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/systolic_ctrl_if.sv
// Control/buffer interface of the systolic tile controller.
//   start_i, k_i, *_base_i        : tile launch request (master -> controller)
//   busy_o, done_o                : status
//   abuf_*, bbuf_*                : operand buffer reads (1-cycle latency)
//   clear_o, we_o                 : accumulator clear / psum capture strobes
//   obuf_we_o, obuf_addr_o, col_sel_o : output buffer write and column select
interface systolic_ctrl_if #(
  parameter int unsigned ADDR_W = 16
);
  import systolic_ctrl_pkg::*;

  logic              start_i;
  logic [K_W-1:0]    k_i;
  logic [ADDR_W-1:0] abuf_base_i;
  logic [ADDR_W-1:0] bbuf_base_i;
  logic [ADDR_W-1:0] obuf_base_i;

  logic              busy_o;
  logic              done_o;
  logic              abuf_re_o;
  logic [ADDR_W-1:0] abuf_addr_o;
  logic              bbuf_re_o;
  logic [ADDR_W-1:0] bbuf_addr_o;
  logic              clear_o;
  logic              we_o;
  logic              obuf_we_o;
  logic [ADDR_W-1:0] obuf_addr_o;
  logic [COL_W-1:0]  col_sel_o;

  modport master (
    output start_i, k_i, abuf_base_i, bbuf_base_i, obuf_base_i,
    input  busy_o, done_o, abuf_re_o, abuf_addr_o, bbuf_re_o, bbuf_addr_o,
           clear_o, we_o, obuf_we_o, obuf_addr_o, col_sel_o
  );

  modport slave (
    input  start_i, k_i, abuf_base_i, bbuf_base_i, obuf_base_i,
    output busy_o, done_o, abuf_re_o, abuf_addr_o, bbuf_re_o, bbuf_addr_o,
           clear_o, we_o, obuf_we_o, obuf_addr_o, col_sel_o
  );

endinterface

// File: rtl/systolic_ctrl_strobe_delay.sv
// Parameterised 1-bit shift register used to align single-cycle strobes.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   d_i          : strobe in
//   q_o          : strobe out, DEPTH cycles later (registered)
module systolic_ctrl_strobe_delay #(
  parameter int unsigned DEPTH = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [DEPTH-1:0] sr;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sr <= '0;
    end else begin
      sr[0] <= d_i;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  assign q_o = sr[DEPTH-1];

endmodule

// File: rtl/systolic_ctrl.sv
// Tile controller for an 8x8 output-stationary systolic array: streams K
// operand words from the A/B buffers, clears and captures the accumulators,
// waits for the array to drain, then writes the 8 column words out.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   ctrl         : systolic_ctrl_if slave (launch request, buffer strobes, status)
module systolic_ctrl #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DRAIN_LAT = systolic_ctrl_pkg::DRAIN_LAT
) (
  input  logic           clk_i,
  input  logic           rst_i,
  systolic_ctrl_if.slave ctrl
);
  import systolic_ctrl_pkg::*;

  state_t            state_q, state_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic [K_W-1:0]    k_q, k_n;
  logic [ADDR_W-1:0] abase_q, bbase_q, obase_q;
  logic [ADDR_W-1:0] abase_n, bbase_n, obase_n;
  logic              clear_src, we_src;
  logic              clear_q, we_q;
  logic              feed_n, write_n;

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    k_n     = k_q;
    abase_n = abase_q;
    bbase_n = bbase_q;
    obase_n = obase_q;
    unique case (state_q)
      ST_IDLE: begin
        if (ctrl.start_i) begin
          k_n     = ctrl.k_i;
          abase_n = ctrl.abuf_base_i;
          bbase_n = ctrl.bbuf_base_i;
          obase_n = ctrl.obuf_base_i;
          cnt_n   = '0;
          state_n = (ctrl.k_i == '0) ? ST_DONE : ST_FEED;
        end
      end
      ST_FEED: begin
        if (cnt_q == CNT_W'(k_q - K_W'(1))) begin
          state_n = ST_FLUSH;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      ST_FLUSH: begin
        state_n = ST_DRAIN;
        cnt_n   = '0;
      end
      // Drain count 0 is the we_o cycle itself, so DRAIN spans DRAIN_LAT cycles.
      ST_DRAIN: begin
        if (cnt_q == CNT_W'(DRAIN_LAT - 1)) begin
          state_n = ST_WRITE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      ST_WRITE: begin
        if (cnt_q == CNT_W'(ARRAY_DIM - 1)) begin
          state_n = ST_DONE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  assign feed_n  = (state_n == ST_FEED);
  assign write_n = (state_n == ST_WRITE);

  // Outputs are registered from next-state values so they line up with the
  // state they describe while staying free of input-to-output paths.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q          <= ST_IDLE;
      cnt_q            <= '0;
      k_q              <= '0;
      abase_q          <= '0;
      bbase_q          <= '0;
      obase_q          <= '0;
      ctrl.busy_o      <= 1'b0;
      ctrl.done_o      <= 1'b0;
      ctrl.abuf_re_o   <= 1'b0;
      ctrl.abuf_addr_o <= '0;
      ctrl.bbuf_re_o   <= 1'b0;
      ctrl.bbuf_addr_o <= '0;
      ctrl.obuf_we_o   <= 1'b0;
      ctrl.obuf_addr_o <= '0;
      ctrl.col_sel_o   <= '0;
    end else begin
      state_q          <= state_n;
      cnt_q            <= cnt_n;
      k_q              <= k_n;
      abase_q          <= abase_n;
      bbase_q          <= bbase_n;
      obase_q          <= obase_n;
      ctrl.busy_o      <= (state_n != ST_IDLE);
      ctrl.done_o      <= (state_n == ST_DONE);
      ctrl.abuf_re_o   <= feed_n;
      ctrl.abuf_addr_o <= feed_n ? abase_n + ADDR_W'(cnt_n) : '0;
      ctrl.bbuf_re_o   <= feed_n;
      ctrl.bbuf_addr_o <= feed_n ? bbase_n + ADDR_W'(cnt_n) : '0;
      ctrl.obuf_we_o   <= write_n;
      ctrl.obuf_addr_o <= write_n ? obase_n + ADDR_W'(cnt_n) : '0;
      ctrl.col_sel_o   <= write_n ? cnt_n[COL_W-1:0] : '0;
    end
  end

  // Two stages: the first lands on FEED cycle 0 / FLUSH, the second one cycle
  // later, when the first / last operand pair reaches the array.
  assign clear_src = feed_n && (cnt_n == '0);
  assign we_src    = (state_n == ST_FLUSH);

  systolic_ctrl_strobe_delay #(.DEPTH(2)) u_clear_dly (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (clear_src),
    .q_o   (clear_q)
  );

  systolic_ctrl_strobe_delay #(.DEPTH(2)) u_we_dly (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (we_src),
    .q_o   (we_q)
  );

  assign ctrl.clear_o = clear_q;
  assign ctrl.we_o    = we_q;

endmodule

// File: tb/tb_systolic_ctrl.sv
// Self-checking bench for systolic_ctrl: per-cycle reference model of the
// tile timeline, table-driven tile vectors, reset/back-to-back sequences and
// a randomized phase.
module tb_systolic_ctrl;
  import systolic_ctrl_pkg::*;

  localparam int unsigned AW = 16;
  localparam int unsigned DL = systolic_ctrl_pkg::DRAIN_LAT;

  typedef struct packed {
    logic          busy;
    logic          done;
    logic          are;
    logic [AW-1:0] aaddr;
    logic          bre;
    logic [AW-1:0] baddr;
    logic          clear;
    logic          we;
    logic          owe;
    logic [AW-1:0] oaddr;
    logic [2:0]    col;
  } outs_t;

  typedef struct {
    logic [7:0]    k;
    logic [AW-1:0] a, b, o;
    int unsigned   reads, clears, wes, writes, done_at;
    logic [AW-1:0] first_a, last_a, last_b, first_o, last_o;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  bit          mon_en = 1'b0;

  always #5 clk = ~clk;

  systolic_ctrl_if #(.ADDR_W(AW)) bus ();

  systolic_ctrl #(.ADDR_W(AW), .DRAIN_LAT(DL)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .ctrl  (bus)
  );

  // Tile timeline: t=1 is the first cycle after the accepting edge.
  function automatic int unsigned tile_len(input int unsigned k);
    return (k == 0) ? 1 : k + 10 + DL;
  endfunction

  function automatic outs_t expect_at(input int unsigned t, input int unsigned k,
                                      input logic [AW-1:0] a, input logic [AW-1:0] b,
                                      input logic [AW-1:0] o);
    outs_t e;
    int unsigned wt;
    e = '0;
    if (t == 0) return e;
    e.busy = 1'b1;
    if (k == 0) begin
      e.done = (t == 1);
      return e;
    end
    if (t <= k) begin
      e.are = 1'b1; e.aaddr = a + AW'(t - 1);
      e.bre = 1'b1; e.baddr = b + AW'(t - 1);
    end
    e.clear = (t == 2);
    e.we    = (t == k + 2);
    wt = k + 2 + DL;
    if (t >= wt && t < wt + 8) begin
      e.owe = 1'b1; e.col = 3'(t - wt); e.oaddr = o + AW'(t - wt);
    end
    e.done = (t == wt + 8);
    return e;
  endfunction

  // Reference model state: position in the current tile and captured request.
  int unsigned   m_t = 0;
  int unsigned   m_k = 0;
  logic [AW-1:0] m_a = '0, m_b = '0, m_o = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) m_t <= 0;
    else if (m_t != 0) m_t <= (m_t == tile_len(m_k)) ? 0 : m_t + 1;
    else if (bus.start_i === 1'b1) begin
      m_t <= 1;
      m_k <= 32'(bus.k_i);
      m_a <= bus.abuf_base_i;
      m_b <= bus.bbuf_base_i;
      m_o <= bus.obuf_base_i;
    end
  end

  // Event counters observed on the DUT outputs.
  int unsigned   n_rd, n_bre, n_clr, n_we, n_wr, n_done;
  logic [AW-1:0] f_a, l_a, l_b, f_o, l_o;
  logic [2:0]    f_col, l_col;
  outs_t         mon_e;
  bit            mon_ok;

  always @(negedge clk) begin
    if (mon_en) begin
      mon_e  = expect_at(m_t, m_k, m_a, m_b, m_o);
      mon_ok = (bus.busy_o === mon_e.busy) && (bus.done_o === mon_e.done)
            && (bus.abuf_re_o === mon_e.are) && (bus.bbuf_re_o === mon_e.bre)
            && (bus.clear_o === mon_e.clear) && (bus.we_o === mon_e.we)
            && (bus.obuf_we_o === mon_e.owe)
            && (!mon_e.are || bus.abuf_addr_o === mon_e.aaddr)
            && (!mon_e.bre || bus.bbuf_addr_o === mon_e.baddr)
            && (!mon_e.owe || (bus.obuf_addr_o === mon_e.oaddr && bus.col_sel_o === mon_e.col));
      checks++;
      if (!mon_ok) begin
        errors++;
        $display("FAIL cycle t=%0d k=%0d got busy%b done%b re%b/%h/%b/%h clr%b we%b owe%b/%h col%0d exp busy%b done%b re%b/%h/%b/%h clr%b we%b owe%b/%h col%0d",
                 m_t, m_k, bus.busy_o, bus.done_o, bus.abuf_re_o, bus.abuf_addr_o,
                 bus.bbuf_re_o, bus.bbuf_addr_o, bus.clear_o, bus.we_o, bus.obuf_we_o,
                 bus.obuf_addr_o, bus.col_sel_o, mon_e.busy, mon_e.done, mon_e.are,
                 mon_e.aaddr, mon_e.bre, mon_e.baddr, mon_e.clear, mon_e.we, mon_e.owe,
                 mon_e.oaddr, mon_e.col);
      end
    end
    if (bus.abuf_re_o === 1'b1) begin
      if (n_rd == 0) f_a = bus.abuf_addr_o;
      l_a = bus.abuf_addr_o;
      n_rd++;
    end
    if (bus.bbuf_re_o === 1'b1) begin
      l_b = bus.bbuf_addr_o;
      n_bre++;
    end
    if (bus.clear_o === 1'b1) n_clr++;
    if (bus.we_o === 1'b1) n_we++;
    if (bus.obuf_we_o === 1'b1) begin
      if (n_wr == 0) begin f_o = bus.obuf_addr_o; f_col = bus.col_sel_o; end
      l_o = bus.obuf_addr_o; l_col = bus.col_sel_o;
      n_wr++;
    end
    if (bus.done_o === 1'b1) n_done++;
  end

  task automatic clr_counts();
    n_rd = 0; n_bre = 0; n_clr = 0; n_we = 0; n_wr = 0; n_done = 0;
    f_a = '0; l_a = '0; l_b = '0; f_o = '0; l_o = '0; f_col = '0; l_col = '0;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_busy"},  32'(bus.busy_o), 0);
    chk({p, "_done"},  32'(bus.done_o), 0);
    chk({p, "_are"},   32'(bus.abuf_re_o), 0);
    chk({p, "_aaddr"}, 32'(bus.abuf_addr_o), 0);
    chk({p, "_bre"},   32'(bus.bbuf_re_o), 0);
    chk({p, "_baddr"}, 32'(bus.bbuf_addr_o), 0);
    chk({p, "_clear"}, 32'(bus.clear_o), 0);
    chk({p, "_we"},    32'(bus.we_o), 0);
    chk({p, "_owe"},   32'(bus.obuf_we_o), 0);
    chk({p, "_oaddr"}, 32'(bus.obuf_addr_o), 0);
    chk({p, "_col"},   32'(bus.col_sel_o), 0);
  endtask

  // Waits (bounded) for done_o; optionally drops start and scrambles the
  // request inputs after the first cycle, which must not affect the tile.
  task automatic wait_done(input bit drop, output int unsigned done_at);
    done_at = 0;
    for (int unsigned c = 1; c <= 600 && done_at == 0; c++) begin
      @(negedge clk); #1;
      if (drop) begin
        bus.start_i     = 1'b0;
        bus.k_i         = 8'($urandom);
        bus.abuf_base_i = AW'($urandom);
        bus.bbuf_base_i = AW'($urandom);
        bus.obuf_base_i = AW'($urandom);
      end
      if (bus.done_o === 1'b1) done_at = c;
    end
    if (done_at == 0) begin
      checks++; errors++;
      $display("FAIL done_timeout got=no done_o required=done_o within 600 cycles");
    end
  endtask

  task automatic launch(input logic [7:0] k, input logic [AW-1:0] a,
                        input logic [AW-1:0] b, input logic [AW-1:0] o);
    @(negedge clk); #1;
    clr_counts();
    bus.start_i = 1'b1; bus.k_i = k;
    bus.abuf_base_i = a; bus.bbuf_base_i = b; bus.obuf_base_i = o;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[5];
    int unsigned dat;
    int unsigned d1;

    bus.start_i = 1'b0; bus.k_i = '0;
    bus.abuf_base_i = '0; bus.bbuf_base_i = '0; bus.obuf_base_i = '0;
    clr_counts();
    #1 rst = 1'b1;
    #2 chk_zero("reset");
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;

    vecs[0] = '{k:8'd4, a:16'h0010, b:16'h0020, o:16'h0030, reads:4, clears:1, wes:1,
                writes:8, done_at:4 + 10 + DL, first_a:16'h0010, last_a:16'h0013,
                last_b:16'h0023, first_o:16'h0030, last_o:16'h0037};
    vecs[1] = '{k:8'd0, a:16'h0005, b:16'h0006, o:16'h0007, reads:0, clears:0, wes:0,
                writes:0, done_at:1, first_a:16'h0, last_a:16'h0, last_b:16'h0,
                first_o:16'h0, last_o:16'h0};
    vecs[2] = '{k:8'd4, a:16'hFFFE, b:16'h0100, o:16'hFFFC, reads:4, clears:1, wes:1,
                writes:8, done_at:4 + 10 + DL, first_a:16'hFFFE, last_a:16'h0001,
                last_b:16'h0103, first_o:16'hFFFC, last_o:16'h0003};
    vecs[3] = '{k:8'd1, a:16'h1234, b:16'hABCD, o:16'h0000, reads:1, clears:1, wes:1,
                writes:8, done_at:1 + 10 + DL, first_a:16'h1234, last_a:16'h1234,
                last_b:16'hABCD, first_o:16'h0000, last_o:16'h0007};
    vecs[4] = '{k:8'd255, a:16'h0000, b:16'hFF01, o:16'h0008, reads:255, clears:1, wes:1,
                writes:8, done_at:255 + 10 + DL, first_a:16'h0000, last_a:16'h00FE,
                last_b:16'hFFFF, first_o:16'h0008, last_o:16'h000F};

    foreach (vecs[i]) begin
      launch(vecs[i].k, vecs[i].a, vecs[i].b, vecs[i].o);
      wait_done(1'b1, dat);
      repeat (3) @(negedge clk);
      #1;
      chk($sformatf("v%0d_done_at", i), dat, vecs[i].done_at);
      chk($sformatf("v%0d_done_cnt", i), n_done, 1);
      chk($sformatf("v%0d_reads", i), n_rd, vecs[i].reads);
      chk($sformatf("v%0d_breads", i), n_bre, vecs[i].reads);
      chk($sformatf("v%0d_clears", i), n_clr, vecs[i].clears);
      chk($sformatf("v%0d_wes", i), n_we, vecs[i].wes);
      chk($sformatf("v%0d_writes", i), n_wr, vecs[i].writes);
      if (vecs[i].reads != 0) begin
        chk($sformatf("v%0d_first_a", i), 32'(f_a), 32'(vecs[i].first_a));
        chk($sformatf("v%0d_last_a", i), 32'(l_a), 32'(vecs[i].last_a));
        chk($sformatf("v%0d_last_b", i), 32'(l_b), 32'(vecs[i].last_b));
      end
      if (vecs[i].writes != 0) begin
        chk($sformatf("v%0d_first_o", i), 32'(f_o), 32'(vecs[i].first_o));
        chk($sformatf("v%0d_last_o", i), 32'(l_o), 32'(vecs[i].last_o));
        chk($sformatf("v%0d_first_col", i), 32'(f_col), 0);
        chk($sformatf("v%0d_last_col", i), 32'(l_col), 7);
      end
    end

    // Reset in FEED cycle 2 of a K=8 tile.
    launch(8'd8, 16'h0040, 16'h0080, 16'h00C0);
    @(negedge clk); #1 bus.start_i = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    chk("prerst_re", 32'(bus.abuf_re_o), 1);
    chk("prerst_addr", 32'(bus.abuf_addr_o), 32'h42);
    rst = 1'b1;
    #1 chk_zero("midfeed_rst");
    @(negedge clk); #1 rst = 1'b0;
    clr_counts();
    repeat (40) @(negedge clk);
    #1;
    chk("postrst_reads", n_rd, 0);
    chk("postrst_clears", n_clr, 0);
    chk("postrst_wes", n_we, 0);
    chk("postrst_writes", n_wr, 0);
    chk("postrst_done", n_done, 0);

    // start_i held high for a whole K=255 tile: re-accepted right after DONE.
    launch(8'd255, 16'h0100, 16'h0200, 16'h0300);
    wait_done(1'b0, d1);
    chk("hold_done_at", d1, 255 + 10 + DL);
    @(negedge clk); #1;
    chk("hold_gap_busy", 32'(bus.busy_o), 0);
    @(negedge clk); #1;
    chk("hold_reaccept_busy", 32'(bus.busy_o), 1);
    chk("hold_reaccept_re", 32'(bus.abuf_re_o), 1);
    wait_done(1'b1, d1);
    repeat (2) @(negedge clk);
    #1;
    chk("hold_done_cnt", n_done, 2);
    chk("hold_reads", n_rd, 510);
    chk("hold_writes", n_wr, 16);

    // Randomized requests, mid-tile input churn and occasional resets.
    for (int unsigned n = 0; n < 4000; n++) begin
      @(negedge clk); #1;
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 499) == 0) rst = 1'b1;
      bus.start_i = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 9))
        0:       bus.k_i = 8'd0;
        1:       bus.k_i = 8'd255;
        2, 3, 4: bus.k_i = 8'($urandom_range(1, 3));
        default: bus.k_i = 8'($urandom_range(1, 40));
      endcase
      bus.abuf_base_i = AW'($urandom);
      bus.bbuf_base_i = AW'($urandom_range(0, 7)) - AW'(4);
      bus.obuf_base_i = AW'($urandom);
    end
    @(negedge clk); #1;
    rst = 1'b0;
    bus.start_i = 1'b0;
    repeat (300) @(negedge clk);
    #1;
    chk("final_idle_busy", 32'(bus.busy_o), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
